// File: rtl/mult_share_arbiter_if.sv
// Handshake bundle for mult_share_arbiter: four requesters in,
// one shared sign-magnitude product out, plus a result counter.
interface mult_share_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic [1:0]  res_id;
  logic        res_ready;
  logic [15:0] op_count;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output res_ready,
    input  req_ready,
    input  res_valid,
    input  res_data,
    input  res_id,
    input  op_count
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  res_ready,
    output req_ready,
    output res_valid,
    output res_data,
    output res_id,
    output op_count
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 8x8 sign-magnitude multiplier.
// Define MULT_SHARE_PIPE_EN to add a PIPE stage after the multiply.
module eight_bit_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [13:0] mag;

  assign mag = {7'b0, a[6:0]} * {7'b0, b[6:0]};
  assign p   = {a[7] ^ b[7], 1'b0, mag};
endmodule

module mult_share_arbiter (
  input  logic           clk,
  input  logic           rst,
  mult_share_arbiter_if.slave bus
);
`ifdef MULT_SHARE_PIPE_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    PIPE = 2'd2,
    RESP = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd3
  } state_t;
`endif

  state_t      state;
  state_t      state_nx;
  logic [1:0]  rr_ptr;
  logic [1:0]  gnt_id;
  logic [1:0]  idx;
  logic        found;
  logic        take;
  logic [3:0]  gnt;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [1:0]  op_id;
  logic [15:0] prod;
  logic [15:0] res_q;
  logic [1:0]  res_id_q;
  logic [15:0] cnt_q;
  logic        res_hs;
`ifdef MULT_SHARE_PIPE_EN
  logic [15:0] raw_q;
`endif

  // Magnitude zero means the sign is meaningless; never emit -0.
  function automatic logic [15:0] fix_zero(
    input logic [15:0] p
  );
    return {p[15] & (|p[14:0]), p[14:0]};
  endfunction

  always_comb begin
    found  = 1'b0;
    gnt_id = rr_ptr;
    idx    = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + i[1:0];
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
    gnt = found ? (4'b0001 << gnt_id) : 4'b0000;
  end

  assign take   = (state == IDLE) && found;
  assign res_hs = (state == RESP) && bus.res_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (take) state_nx = MUL;
`ifdef MULT_SHARE_PIPE_EN
      MUL:  state_nx = PIPE;
      PIPE: state_nx = RESP;
`else
      MUL:  state_nx = RESP;
`endif
      RESP: if (bus.res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 4'b0000;
    bus.res_valid = 1'b0;
    unique case (1'b1)
      state == IDLE: bus.req_ready = gnt;
      state == RESP: bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 2'd0;
      op_a   <= 8'd0;
      op_b   <= 8'd0;
      op_id  <= 2'd0;
    end else if (take) begin
      rr_ptr <= gnt_id + 2'd1;
      op_a   <= bus.req_a[8*gnt_id +: 8];
      op_b   <= bus.req_b[8*gnt_id +: 8];
      op_id  <= gnt_id;
    end
  end

  eight_bit_multiplier u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

`ifdef MULT_SHARE_PIPE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q    <= 16'd0;
      res_q    <= 16'd0;
      res_id_q <= 2'd0;
    end else begin
      if (state == MUL) raw_q <= prod;
      if (state == PIPE) begin
        res_q    <= fix_zero(raw_q);
        res_id_q <= op_id;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q    <= 16'd0;
      res_id_q <= 2'd0;
    end else if (state == MUL) begin
      res_q    <= fix_zero(prod);
      res_id_q <= op_id;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= 16'd0;
    else if (res_hs) cnt_q <= cnt_q + 16'd1;
  end

  assign bus.res_data = res_q;
  assign bus.res_id   = res_id_q;
  assign bus.op_count = cnt_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a result scoreboard.
// Follows MULT_SHARE_PIPE_EN for the expected latency.
module tb_mult_share_arbiter;
`ifdef MULT_SHARE_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] fa [4];
  logic [7:0] fb [4];
  logic [7:0] ba;
  logic [7:0] bb;

  always #5 clk = ~clk;

  mult_share_arbiter_if bus ();

  mult_share_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] ref_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    int m;
    m = int'(a[6:0]) * int'(b[6:0]);
    return {(a[7] ^ b[7]) && (m != 0), m[14:0]};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.res_valid === 1'b1 &&
        bus.res_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_underflow observed id=%0d data=0x%0h expected none",
               bus.res_id, bus.res_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("res_id", 32'(bus.res_id), 32'(e.id));
        chk("res_data", 32'(bus.res_data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(
    input int         id,
    input logic [7:0] a,
    input logic [7:0] b
  );
    bus.req_a[8*id +: 8] = a;
    bus.req_b[8*id +: 8] = b;
  endtask

  task automatic push(
    input int         id,
    input logic [7:0] a,
    input logic [7:0] b
  );
    exp_t e;
    e.id   = 2'(id);
    e.data = ref_mul(a, b);
    sbq.push_back(e);
  endtask

  // Waits for any grant, checks it, then steps past the grant edge.
  task automatic grant_wait(
    input logic [3:0] exp,
    input string      tag
  );
    int t;
    t = 0;
    #1;
    while (bus.req_ready == 4'b0 && t < 20) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk(tag, 32'(bus.req_ready), 32'(exp));
    tick();
  endtask

  task automatic check_lat();
    int lat;
    lat = 1;
    while (bus.res_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency", lat, LAT);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 30) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", sbq.size(), 0);
  endtask

  task automatic single(
    input int         id,
    input logic [7:0] a,
    input logic [7:0] b,
    input string      tag
  );
    set_op(id, a, b);
    push(id, a, b);
    bus.req_valid = 4'(1 << id);
    grant_wait(4'(1 << id), tag);
    bus.req_valid = 4'b0;
    check_lat();
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 4'b0;
    bus.req_a     = 32'b0;
    bus.req_b     = 32'b0;
    bus.res_ready = 1'b1;
    repeat (2) tick();
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_op_count", 32'(bus.op_count), 0);
    chk("rst_res_data", 32'(bus.res_data), 0);
    chk("rst_res_id", 32'(bus.res_id), 0);
    rst = 1'b0;
    tick();

    single(0, 8'h85, 8'h03, "gnt_single");
    chk("op_count_1", 32'(bus.op_count), 1);
    single(1, 8'h7F, 8'hFF, "gnt_max_neg");
    single(2, 8'hFF, 8'hFF, "gnt_max_pos");
    single(3, 8'h80, 8'h05, "gnt_negzero");
    single(0, 8'h00, 8'h85, "gnt_poszero");
    chk("op_count_5", 32'(bus.op_count), 5);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("op_count_rst", 32'(bus.op_count), 0);
    for (int i = 0; i < 4; i++) begin
      fa[i] = 8'($urandom);
      fb[i] = 8'($urandom);
      set_op(i, fa[i], fb[i]);
    end
    for (int k = 0; k < 5; k++) push(k % 4, fa[k%4], fb[k%4]);
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++)
      grant_wait(4'(1 << (k % 4)), "fair_gnt");
    bus.req_valid = 4'b0;
    drain();
    chk("fair_op_count", 32'(bus.op_count), 5);

    bus.res_ready = 1'b0;
    ba = 8'($urandom);
    bb = 8'($urandom) | 8'h01;
    ba[6:0] = ba[6:0] | 7'h01;
    set_op(2, ba, bb);
    push(2, ba, bb);
    bus.req_valid = 4'b0100;
    grant_wait(4'b0100, "bp_gnt");
    set_op(3, 8'h9C, 8'h0B);
    push(3, 8'h9C, 8'h0B);
    bus.req_valid = 4'b1000;
    check_lat();
    for (int c = 0; c < 10; c++) begin
      chk("bp_res_valid", 32'(bus.res_valid), 1);
      chk("bp_res_data", 32'(bus.res_data), 32'(ref_mul(ba, bb)));
      chk("bp_res_id", 32'(bus.res_id), 2);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
      chk("bp_op_count", 32'(bus.op_count), 5);
      tick();
    end
    bus.res_ready = 1'b1;
    grant_wait(4'b1000, "pend_gnt");
    bus.req_valid = 4'b0;
    drain();
    chk("bp_op_count_after", 32'(bus.op_count), 7);

    set_op(1, 8'h33, 8'h44);
    bus.req_valid = 4'b0010;
    grant_wait(4'b0010, "mid_gnt");
    bus.req_valid = 4'b0;
    rst = 1'b1;
    tick();
    chk("mid_res_valid", 32'(bus.res_valid), 0);
    chk("mid_op_count", 32'(bus.op_count), 0);
    chk("mid_req_ready", 32'(bus.req_ready), 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("mid_no_resp", 32'(bus.res_valid), 0);
    single(2, 8'h8A, 8'h0C, "post_rst_gnt");
    chk("post_rst_op_count", 32'(bus.op_count), 1);

    chk("sb_final", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter: none; requester count fixed at 4, operand width fixed at 8 bits sign-magnitude.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req_valid  input  4  per-requester operand-pair valid; bit i is requester i.
REQ-005 Port: req_a  input  32  packed operand A; requester i at [8i+7:8i]; bit 7 sign, bits 6:0 magnitude.
REQ-006 Port: req_b  input  32  packed operand B; same packing and format as req_a.
REQ-007 Port: req_ready  output  4  one-hot grant/accept; handshake completes when req_valid[i] and req_ready[i] are both 1.
REQ-008 Port: res_valid  output  1  result available.
REQ-009 Port: res_data  output  16  sign-magnitude product; bit 15 sign, bits 14:0 magnitude.
REQ-010 Port: res_id  output  2  index of the requester that owns res_data.
REQ-011 Port: res_ready  input  1  result consumer accept.
REQ-012 Port: op_count  output  16  count of completed result handshakes.

Function
REQ-013 The block SHALL contain exactly one shared eight_bit_multiplier instance, fed only from internal operand registers.
REQ-014 The FSM SHALL have states IDLE, MUL, PIPE (present only with the macro, REQ-028) and RESP.
REQ-015 req_ready SHALL be all-zero outside IDLE; in IDLE it SHALL be combinational and carry at most one bit set.
REQ-016 Arbitration in IDLE SHALL grant the first asserted req_valid bit found scanning upward from rr_ptr, modulo 4.
REQ-017 On grant, the block SHALL latch the granted requester's A, B and index, set rr_ptr to (grant+1) mod 4, and move to MUL.
REQ-018 If no req_valid bit is set in IDLE, the block SHALL stay in IDLE with rr_ptr unchanged.
REQ-019 MUL SHALL last exactly one cycle; without the macro it SHALL register the product into res_data and res_id and go to RESP.
REQ-020 The product SHALL be: sign = A[7] XOR B[7]; magnitude = A[6:0] x B[6:0], zero-extended to 15 bits.
REQ-021 If the magnitude is zero, the sign bit SHALL be forced to 0, so negative zero is never output.
REQ-022 In RESP, res_valid SHALL be 1 and res_data and res_id SHALL stay stable until res_ready is sampled high.
REQ-023 On the res_valid and res_ready handshake, the block SHALL return to IDLE and op_count SHALL increment, wrapping from 0xFFFF to 0x0000.
REQ-024 Latency from the grant edge to res_valid=1 SHALL be 2 cycles without the macro and 3 cycles with it.
REQ-025 Maximum throughput SHALL be one result every 3 cycles without the macro and every 4 cycles with it.
REQ-026 Requests arriving outside IDLE SHALL be neither accepted nor lost; they SHALL be arbitrated at the next IDLE cycle.

Reset
REQ-027 When rst is sampled high, the block SHALL go to IDLE and clear rr_ptr, the operand registers, res_data, res_id and op_count to 0, and drive res_valid to 0; an in-flight transaction is discarded without a response.

Configuration
REQ-028 When macro MULT_SHARE_PIPE_EN is defined, MUL SHALL register the raw multiplier output, and PIPE (one cycle) SHALL apply REQ-021 and load res_data and res_id before RESP.
REQ-029 When MULT_SHARE_PIPE_EN is undefined, PIPE and its register SHALL not exist, and MUL SHALL go directly to RESP.

Verification
REQ-030 Single request: req_valid=0001, A=0x85, B=0x03, res_ready=1 -> res_data=0x800F, res_id=0, res_valid at grant+2 (grant+3 with macro).
REQ-031 Maximum magnitude: A=0x7F, B=0xFF -> res_data=0xBF01; A=0xFF, B=0xFF -> res_data=0x3F01.
REQ-032 Zero sign: A=0x80, B=0x05 -> res_data=0x0000; A=0x00, B=0x85 -> res_data=0x0000.
REQ-033 Fairness: req_valid=1111 held, rr_ptr=0 -> grants in order 0,1,2,3,0, each res_id matching its grant, op_count=5 after five results.
REQ-034 Backpressure: res_ready=0 for 10 cycles in RESP -> res_valid, res_data and res_id stay stable, req_ready=0000, op_count unchanged.
REQ-035 Reset mid-operation: rst=1 during MUL -> next cycle IDLE, res_valid=0, op_count=0; a subsequent request from requester 2 with rr_ptr=0 is granted normally.
